// File: rtl/scan_pkg.sv
// Shared types and default sizing for the channel scan sequencer.
package scan_pkg;

    localparam int DEF_SIZE   = 5;
    localparam int DEF_HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the scan sequencer.
interface scan_sequencer_if
    import scan_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int HOLD_W = DEF_HOLD_W
);

    logic                 start_i;
    logic                 stop_i;
    logic [2**SIZE-1:0]   mask_i;
    logic [HOLD_W-1:0]    hold_i;
    logic                 cont_i;
    logic [SIZE-1:0]      idx_o;
    logic                 valid_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output start_i, stop_i, mask_i, hold_i, cont_i,
        input  idx_o, valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, mask_i, hold_i, cont_i,
        output idx_o, valid_o, busy_o, done_o
    );

endinterface

// File: rtl/scan_sequencer_next_set_finder.sv
// Combinational search of a channel mask: next set bit above an index, and lowest set bit.
module next_set_finder
    import scan_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic [2**SIZE-1:0] mask_i,
    input  logic [SIZE-1:0]    cur_i,
    output logic [SIZE-1:0]    next_o,
    output logic               found_o,
    output logic [SIZE-1:0]    low_o
);

    // Descending scan: the final hit is the smallest qualifying index.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        low_o   = '0;
        for (int i = 2**SIZE - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low_o = SIZE'(i);
                if (SIZE'(i) > cur_i) begin
                    next_o  = SIZE'(i);
                    found_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a channel index through the enabled bits of a latched mask, dwelling hold+1 cycles on each.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    scan_sequencer_if.slave  bus
);

    localparam int N = 2**SIZE;

    state_e            state_q, state_d;
    logic [SIZE-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cont_q, cont_d;

    logic [N-1:0]      find_mask;
    logic [SIZE-1:0]   next_idx;
    logic              next_found;
    logic [SIZE-1:0]   low_idx;

    // In IDLE the live mask is searched so the first index is ready on the start edge.
    assign find_mask = (state_q == IDLE) ? bus.mask_i : mask_q;

    next_set_finder #(.SIZE(SIZE)) u_finder (
        .mask_i  (find_mask),
        .cur_i   (idx_q),
        .next_o  (next_idx),
        .found_o (next_found),
        .low_o   (low_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        hold_d  = hold_q;
        cont_d  = cont_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start_i) begin
                    mask_d = bus.mask_i;
                    hold_d = bus.hold_i;
                    cont_d = bus.cont_i;
                    if (|bus.mask_i) begin
                        state_d = SCAN;
                        idx_d   = low_idx;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                // Stop outranks a coincident dwell end, so the index is left untouched.
                if (bus.stop_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == hold_q) begin
                    cnt_d = '0;
                    if (next_found) begin
                        idx_d = next_idx;
                    end else if (cont_q) begin
                        idx_d = low_idx;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= '0;
            hold_q  <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            cont_q  <= cont_d;
        end
    end

    assign bus.idx_o   = idx_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed and randomized scans of scan_sequencer compared against a list-based channel model.
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam int SIZE   = DEF_SIZE;
    localparam int HOLD_W = DEF_HOLD_W;
    localparam int N      = 2**SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;

    scan_sequencer_if #(.SIZE(SIZE), .HOLD_W(HOLD_W)) bus ();

    scan_sequencer #(.SIZE(SIZE), .HOLD_W(HOLD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int last_idx = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic b, input logic d, input int idx);
        chk({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
        chk({tag, ".busy"},  32'(bus.busy_o),  32'(b));
        chk({tag, ".done"},  32'(bus.done_o),  32'(d));
        chk({tag, ".idx"},   32'(bus.idx_o),   32'(idx));
    endtask

    // Scramble the request inputs; a running scan must not notice.
    task automatic perturb();
        bus.mask_i  = $urandom;
        bus.hold_i  = HOLD_W'($urandom);
        bus.cont_i  = 1'($urandom);
        bus.start_i = 1'($urandom);
    endtask

    // Expected index list for one pass: each enabled channel, ascending, hold+1 times.
    task automatic build_pass(input logic [N-1:0] m, input int h);
        exp_q.delete();
        for (int b = 0; b < N; b++)
            if (m[b])
                for (int r = 0; r <= h; r++) exp_q.push_back(b);
    endtask

    task automatic launch(input logic [N-1:0] m, input int h, input logic c);
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b0;
        bus.mask_i  = m;
        bus.hold_i  = HOLD_W'(h);
        bus.cont_i  = c;
        cycle();
        bus.start_i = 1'b0;
    endtask

    // Ends with the done cycle showing; the caller decides what follows it.
    task automatic run_single(input logic [N-1:0] m, input int h);
        build_pass(m, h);
        launch(m, h, 1'b0);
        while (exp_q.size() > 0) begin
            last_idx = exp_q.pop_front();
            chk_out("single", 1'b1, 1'b1, 1'b0, last_idx);
            perturb();
            cycle();
        end
        bus.start_i = 1'b0;
        chk_out("single_end", 1'b0, 1'b0, 1'b1, last_idx);
    endtask

    task automatic run_cont(input logic [N-1:0] m, input int h, input int n);
        int per[$];
        build_pass(m, h);
        per = exp_q;
        launch(m, h, 1'b1);
        for (int k = 0; k < n; k++) begin
            last_idx = per[k % per.size()];
            chk_out("cont", 1'b1, 1'b1, 1'b0, last_idx);
            perturb();
            bus.stop_i = (k == n - 1);
            cycle();
            bus.stop_i = 1'b0;
        end
        bus.start_i = 1'b0;
        chk_out("cont_stop", 1'b0, 1'b0, 1'b1, last_idx);
    endtask

    task automatic idle_chk();
        cycle();
        chk_out("idle", 1'b0, 1'b0, 1'b0, last_idx);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.mask_i  = '0;
        bus.hold_i  = '0;
        bus.cont_i  = 1'b0;
        @(negedge clk);
        cycle();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        last_idx = 0;

        bus.stop_i = 1'b1;
        cycle();
        bus.stop_i = 1'b0;
        chk_out("idle_stop", 1'b0, 1'b0, 1'b0, 0);

        run_single(32'h0000_0005, 0);
        idle_chk();

        run_single(32'h0000_0000, 3);
        idle_chk();

        run_cont(32'h8000_0001, 2, 10);
        idle_chk();

        run_cont(32'h8000_0001, 2, 9);
        idle_chk();

        run_cont(32'h0000_0100, 0, 5);
        idle_chk();

        run_single(32'hFFFF_FFFF, 255);
        run_single(32'h0000_00A0, 1);
        idle_chk();

        launch(32'hFFFF_FFFF, 0, 1'b1);
        repeat (5) cycle();
        chk_out("pre_rst", 1'b1, 1'b1, 1'b0, 5);
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        cycle();
        chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 0);
        bus.stop_i = 1'b0;
        cycle();
        chk_out("rst_vs_start", 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        last_idx = 0;
        idle_chk();

        for (int t = 0; t < 24; t++) begin
            logic [N-1:0] m;
            int h;
            m = $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) m = '0;
            h = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                run_single(m, h);
            end else begin
                if (m == '0) m = N'(1) << $urandom_range(0, N - 1);
                run_cont(m, h, $urandom_range(1, 40));
            end
            if ($urandom_range(0, 1) == 1) idle_chk();
        end
        idle_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
